// File: rtl/timer_tick_pkg.sv
// Shared definitions for timer_tick_master: timer register map, control bits, FSM states.
// SNAP_* states exist only when FPGASYNTH_TIMER_SNAP_EN is defined.
package timer_tick_pkg;

  localparam logic [3:0] REG_STATUS  = 4'd0;
  localparam logic [3:0] REG_CONTROL = 4'd1;
  localparam logic [3:0] REG_PERIOD0 = 4'd2;
  localparam logic [3:0] REG_SNAP0   = 4'd6;

  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;

  localparam logic [15:0] CTRL_RUN  = 16'h0007;
  localparam logic [15:0] CTRL_STOP = 16'h0008;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PER,
    ST_GAP,
    ST_WR_CTRL,
    ST_RUN,
    ST_CLR_STAT,
    ST_STOP
`ifdef FPGASYNTH_TIMER_SNAP_EN
    ,
    ST_SNAP_WR,
    ST_SNAP_RD
`endif
  } state_t;

  function automatic logic [15:0] period_half(input logic [63:0] p, input logic [1:0] idx);
    logic [15:0] h;
    case (idx)
      2'd0:    h = p[15:0];
      2'd1:    h = p[31:16];
      2'd2:    h = p[47:32];
      default: h = p[63:48];
    endcase
    return h;
  endfunction

endpackage

// File: rtl/timer_tick_master.sv
// Hardware Avalon-MM master that programs and services the interval timer, emitting one tick per timeout.
// Optional counter snapshot after each tick: define FPGASYNTH_TIMER_SNAP_EN.
module timer_tick_master
  import timer_tick_pkg::*;
#(
  parameter int          CNT_W        = 16,
  parameter logic [63:0] RESET_PERIOD = 64'd49999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [63:0]      cfg_period,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             busy,
  output logic [3:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [15:0]      avm_writedata,
  input  logic [15:0]      avm_readdata,
  input  logic             timer_irq,
  output logic [63:0]      snap_value,
  output logic             snap_valid
);

  state_t           r_state, w_state_next;
  logic [2:0]       r_idx, w_idx_next;
  logic [63:0]      r_period;
  logic [CNT_W-1:0] r_tick_count;
  logic             r_live;
  logic             w_accept;

  assign w_accept   = cfg_valid && cfg_ready;
  assign tick_count = r_tick_count;

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = 3'd0;
    cfg_ready      = 1'b0;
    busy           = 1'b1;
    tick           = 1'b0;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 4'd0;
    avm_writedata  = 16'd0;
    case (r_state)
      ST_IDLE: begin
        busy      = 1'b0;
        // r_live keeps cfg_ready low while reset is held
        cfg_ready = r_live;
        if (enable) w_state_next = ST_WR_PER;
      end
      ST_WR_PER: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_PERIOD0 + {2'b00, r_idx[1:0]};
        avm_writedata  = period_half(r_period, r_idx[1:0]);
        w_idx_next     = r_idx + 3'd1;
        if (r_idx[1:0] == 2'd3) begin
          w_idx_next   = 3'd0;
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: w_state_next = ST_WR_CTRL;
      ST_WR_CTRL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_CONTROL;
        avm_writedata  = CTRL_RUN;
        w_state_next   = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b0;
        // A pending irq wins, so a request must not be acknowledged that cycle
        cfg_ready = !timer_irq;
        if (timer_irq)      w_state_next = ST_CLR_STAT;
        else if (!enable)   w_state_next = ST_STOP;
        else if (cfg_valid) w_state_next = ST_WR_PER;
      end
      ST_CLR_STAT: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_STATUS;
        tick           = 1'b1;
`ifdef FPGASYNTH_TIMER_SNAP_EN
        w_state_next   = ST_SNAP_WR;
`else
        w_state_next   = ST_RUN;
`endif
      end
      ST_STOP: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_CONTROL;
        avm_writedata  = CTRL_STOP;
        w_state_next   = ST_IDLE;
      end
`ifdef FPGASYNTH_TIMER_SNAP_EN
      ST_SNAP_WR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_SNAP0;
        w_state_next   = ST_SNAP_RD;
      end
      ST_SNAP_RD: begin
        // Indices 0..3 issue reads; index 4 only collects the last readdata
        w_idx_next = r_idx + 3'd1;
        if (r_idx != 3'd4) begin
          avm_chipselect = 1'b1;
          avm_address    = REG_SNAP0 + {1'b0, r_idx};
        end else begin
          w_idx_next   = 3'd0;
          w_state_next = ST_RUN;
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= 3'd0;
      r_period     <= RESET_PERIOD;
      r_tick_count <= '0;
      r_live       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_live  <= 1'b1;
      if (w_accept) r_period <= cfg_period;
      if (r_state == ST_CLR_STAT) r_tick_count <= r_tick_count + CNT_W'(1);
    end
  end

`ifdef FPGASYNTH_TIMER_SNAP_EN
  logic [47:0] r_snap_buf;
  logic [63:0] r_snap_value;
  logic        r_snap_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap_buf   <= '0;
      r_snap_value <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      r_snap_valid <= 1'b0;
      if (r_state == ST_SNAP_RD) begin
        case (r_idx)
          3'd1: r_snap_buf[15:0]  <= avm_readdata;
          3'd2: r_snap_buf[31:16] <= avm_readdata;
          3'd3: r_snap_buf[47:32] <= avm_readdata;
          3'd4: begin
            r_snap_value <= {avm_readdata, r_snap_buf};
            r_snap_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign snap_value = r_snap_value;
  assign snap_valid = r_snap_valid;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^avm_readdata;
  assign snap_value  = 64'd0;
  assign snap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_timer_tick_master.sv
// Directed bench for timer_tick_master with a behavioural interval-timer slave.
// Snapshot checks compile in when FPGASYNTH_TIMER_SNAP_EN is defined.
module tb_timer_tick_master;

  localparam logic [63:0] SNAP_FROZEN = 64'h1122_3344_5566_7788;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [63:0] cfg_period;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        tick;
  logic [15:0] tick_count;
  logic        busy;
  logic [3:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        timer_irq;
  logic [63:0] snap_value;
  logic        snap_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  timer_tick_master #(.CNT_W(16), .RESET_PERIOD(64'd49999)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .cfg_period(cfg_period), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .tick(tick), .tick_count(tick_count), .busy(busy),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .timer_irq(timer_irq),
    .snap_value(snap_value), .snap_valid(snap_valid)
  );

  always #5 clk = ~clk;

  // Interval timer slave: period writes stop and force-reload, START/STOP in control.
  logic [63:0] m_period = 64'd0;
  logic [63:0] m_cnt    = 64'd0;
  logic [63:0] m_snap   = 64'd0;
  logic        m_run    = 1'b0;
  logic        m_to     = 1'b0;
  logic        m_ito    = 1'b0;
  logic [15:0] m_rd     = 16'd0;

  assign avm_readdata = m_rd;
  assign timer_irq    = m_to && m_ito;

  always @(posedge clk) begin : timer_model
    logic [63:0] np;
    logic        pw;
    np = m_period;
    pw = 1'b0;
    if (avm_chipselect && !avm_write_n) begin
      case (avm_address)
        4'd0: m_to <= 1'b0;
        4'd1: begin
          m_ito <= avm_writedata[0];
          if (avm_writedata[2]) m_run <= 1'b1;
          if (avm_writedata[3]) m_run <= 1'b0;
        end
        4'd2: begin np[15:0]  = avm_writedata; pw = 1'b1; end
        4'd3: begin np[31:16] = avm_writedata; pw = 1'b1; end
        4'd4: begin np[47:32] = avm_writedata; pw = 1'b1; end
        4'd5: begin np[63:48] = avm_writedata; pw = 1'b1; end
        4'd6: m_snap <= SNAP_FROZEN;
        default: ;
      endcase
    end
    if (avm_chipselect && avm_write_n) begin
      case (avm_address)
        4'd6: m_rd <= m_snap[15:0];
        4'd7: m_rd <= m_snap[31:16];
        4'd8: m_rd <= m_snap[47:32];
        4'd9: m_rd <= m_snap[63:48];
        default: m_rd <= 16'd0;
      endcase
    end
    if (pw) begin
      m_period <= np;
      m_cnt    <= np;
      m_run    <= 1'b0;
    end else if (m_run) begin
      if (m_cnt == 64'd0) begin
        m_to  <= 1'b1;
        m_cnt <= m_period;
      end else begin
        m_cnt <= m_cnt - 64'd1;
      end
    end
  end

  logic [21:0] bus_obs;
  assign bus_obs = {avm_chipselect, avm_write_n, avm_address, avm_writedata};

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input string tag, input logic [3:0] a, input logic [15:0] d);
    chk(tag, 64'(bus_obs), 64'({2'b10, a, d}));
  endtask

  // Entered at the negedge of the first period write; returns at the first RUN negedge.
  task automatic expect_prog(input string tag, input logic [63:0] p);
    expect_wr({tag, "_p0"}, 4'd2, p[15:0]);  chk({tag, "_busy"}, 64'(busy), 64'd1); step();
    expect_wr({tag, "_p1"}, 4'd3, p[31:16]); step();
    expect_wr({tag, "_p2"}, 4'd4, p[47:32]); step();
    expect_wr({tag, "_p3"}, 4'd5, p[63:48]); step();
    chk({tag, "_gap"}, 64'({avm_chipselect, avm_write_n}), 64'd1);
    chk({tag, "_gap_ready"}, 64'(cfg_ready), 64'd0); step();
    expect_wr({tag, "_ctrl"}, 4'd1, 16'h0007); step();
    chk({tag, "_run_busy"}, 64'(busy), 64'd0);
    chk({tag, "_run_ready"}, 64'(cfg_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t;
    int   last_t;
    int   ntk;
    int   n;
    logic prev_irq;

    reset_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_period = 64'd0;
    repeat (3) step();
    chk("rst_bus",        64'(bus_obs),    64'({2'b01, 4'd0, 16'd0}));
    chk("rst_tick",       64'(tick),       64'd0);
    chk("rst_tick_count", 64'(tick_count), 64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_cfg_ready",  64'(cfg_ready),  64'd0);
    chk("rst_snap_value", snap_value,      64'd0);
    chk("rst_snap_valid", 64'(snap_valid), 64'd0);

    reset_n = 1'b1; step();
    chk("idle_ready", 64'(cfg_ready), 64'd1);
    enable = 1'b1; step();
    expect_prog("boot", 64'd49999);

    // Program period 9: the model times out every 10 cycles
    cfg_period = 64'd9; cfg_valid = 1'b1;
    chk("cfg9_ready", 64'(cfg_ready), 64'd1);
    step(); cfg_valid = 1'b0;
    expect_prog("cfg9", 64'd9);

    t = 0; last_t = -1; ntk = 0; prev_irq = 1'b0;
    while (ntk < 5 && t < 300) begin
      step(); t++;
      if (tick) begin
        expect_wr("tick_clr_bus", 4'd0, 16'd0);
        chk("tick_latency", 64'(prev_irq), 64'd1);
        chk("tick_ready_low", 64'(cfg_ready), 64'd0);
        if (last_t >= 0) chk("tick_interval", 64'(t - last_t), 64'd10);
`ifndef FPGASYNTH_TIMER_SNAP_EN
        chk("nosnap_valid", 64'(snap_valid), 64'd0);
`endif
        last_t = t; ntk++;
      end
      prev_irq = timer_irq;
    end
    chk("ticks_seen", 64'(ntk), 64'd5);
    step();
    chk("tick_count_5", 64'(tick_count), 64'd5);

    // Request arriving together with an irq: service first, then reprogram
    n = 0;
    while (!timer_irq && n < 100) begin step(); n++; end
    chk("irq_seen", 64'(timer_irq), 64'd1);
    cfg_period = 64'hA5A5_0003_0002_0013; cfg_valid = 1'b1;
    chk("irq_cfg_ready", 64'(cfg_ready), 64'd0);
    step();
    chk("irq_cfg_tick", 64'(tick), 64'd1);
    expect_wr("irq_cfg_clr", 4'd0, 16'd0);
    chk("irq_cfg_ready_clr", 64'(cfg_ready), 64'd0);
`ifdef FPGASYNTH_TIMER_SNAP_EN
    repeat (6) begin step(); chk("irq_cfg_ready_snap", 64'(cfg_ready), 64'd0); end
`endif
    step();
    chk("irq_cfg_ready_back", 64'(cfg_ready), 64'd1);
    step(); cfg_valid = 1'b0;
    expect_prog("newper", 64'hA5A5_0003_0002_0013);

    // Drop enable in RUN
    enable = 1'b0; step();
    expect_wr("stop_wr", 4'd1, 16'h0008);
    chk("stop_busy", 64'(busy), 64'd1);
    step();
    chk("stop_idle_bus", 64'({avm_chipselect, avm_write_n}), 64'd1);
    chk("stop_idle_busy", 64'(busy), 64'd0);
    chk("stop_tick_count", 64'(tick_count), 64'd6);
    repeat (5) step();
    chk("stop_hold_count", 64'(tick_count), 64'd6);
    chk("stop_hold_cs", 64'(avm_chipselect), 64'd0);

    // Reset in the middle of the period writes
    enable = 1'b1; step();
    expect_wr("mid_p0", 4'd2, 16'h0013); step();
    expect_wr("mid_p1", 4'd3, 16'h0002);
    @(posedge clk); #2 reset_n = 1'b0; #1;
    chk("mid_rst_bus",   64'(bus_obs),    64'({2'b01, 4'd0, 16'd0}));
    chk("mid_rst_busy",  64'(busy),       64'd0);
    chk("mid_rst_count", 64'(tick_count), 64'd0);
    chk("mid_rst_ready", 64'(cfg_ready),  64'd0);
    @(negedge clk); reset_n = 1'b1;
    step();
    expect_prog("rearm", 64'd49999);

`ifdef FPGASYNTH_TIMER_SNAP_EN
    cfg_period = 64'd9; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
    expect_prog("snapcfg", 64'd9);
    n = 0;
    while (!timer_irq && n < 100) begin step(); n++; end
    chk("snap_irq_seen", 64'(timer_irq), 64'd1);
    step();
    chk("snap_tick", 64'(tick), 64'd1);
    step();
    expect_wr("snap_wr", 4'd6, 16'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("snap_rd", 64'({avm_chipselect, avm_write_n, avm_address}), 64'({2'b11, 4'(6 + k)}));
      chk("snap_valid_early", 64'(snap_valid), 64'd0);
    end
    step();
    chk("snap_rd_done_cs", 64'(avm_chipselect), 64'd0);
    step();
    chk("snap_valid_pulse", 64'(snap_valid), 64'd1);
    chk("snap_value", snap_value, SNAP_FROZEN);
    chk("snap_run_ready", 64'(cfg_ready), 64'd1);
    step();
    chk("snap_valid_once", 64'(snap_valid), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
